rtc_bus_sequencer: RTL and testbench
====================================

// Module: rtc_bus_sequencer
// PURPOSE
//  Shares the multiplexed address/data bus of the RTC chip among the control sub-FSMs:
//  init, hora write, fecha write, crono write and edatos read.
//  Grants one requester at a time by fixed priority and runs one complete Intel-style
//  bus cycle per grant: address phase, then data phase (write or read).
//  Sits between the requester sub-FSMs and the RTC pads; nothing else drives the bus.
// PARAMETERS
//  NREQ   5  number of requesters; index 0 = highest priority (0 init,1 ghora,2 gfecha,3 gcrono,4 edatos)
//  T_SU   2  setup cycles before each strobe (1..255)
//  T_PW   4  strobe low width in cycles (1..255)
//  T_H    2  hold cycles after each strobe (1..255)
//  T_GAP  3  cycles with cs_n high between transactions (1..255)
// PORTS
//  clock      in   1        single system clock, all logic on rising edge
//  reset      in   1        synchronous, active-high
//  req        in   NREQ     request per requester; held until its done
//  req_wr     in   NREQ     1 = write, 0 = read; per requester
//  req_addr   in   8*NREQ   register address; requester i at [8i+7:8i]
//  req_wdata  in   8*NREQ   write data; requester i at [8i+7:8i]
//  gnt        out  NREQ     one-hot grant; at most one bit set
//  done       out  1        1-cycle pulse, transaction complete (with gnt still set)
//  rdata      out  8        read data, valid from done until next read completes
//  busy       out  1        1 in any state except IDLE
//  cs_n rd_n wr_n ad_n  out 1 each   RTC strobes, active low; ad_n=0 address, 1 data
//  ad_out     out  8        bus drive value
//  ad_oe      out  1        pad tristate enable (1 = drive ad_out)
//  ad_in      in   8        bus sample value
// BEHAVIOUR
//  Reset: gnt=0, done=0, rdata=0, busy=0, cs_n=rd_n=wr_n=ad_n=1, ad_out=0, ad_oe=0; state IDLE.
//   Reset mid-transaction aborts: all strobes inactive on the next edge, no done.
//  States: IDLE, A_SU, A_PW, A_H, D_SU, D_PW, D_H, DONE, GAP.
//  IDLE: if req!=0, latch index k = lowest set bit, latch addr/wdata/wr of k, gnt[k]=1, go A_SU.
//  A_SU (T_SU cyc): cs_n=0, ad_n=0, ad_oe=1, ad_out=addr.
//  A_PW (T_PW cyc): as A_SU plus wr_n=0 (address always written).
//  A_H (T_H cyc): wr_n=1, address still driven.
//  D_SU (T_SU): ad_n=1; write: ad_out=wdata, ad_oe=1; read: ad_oe=0.
//  D_PW (T_PW): write: wr_n=0; read: rd_n=0, rdata<=ad_in on last D_PW cycle only.
//  D_H (T_H): strobes high, cs_n=0, ad_oe as D_SU.
//  DONE (1 cyc): done=1, cs_n=1, ad_oe=0; next gnt=0, go GAP.
//  GAP (T_GAP cyc): cs_n=1, then IDLE; re-arbitration only in IDLE.
//  Latency: gnt rises 1 cycle after req seen in IDLE; done in cycle 2*(T_SU+T_PW+T_H)+1
//   of gnt (17 with defaults); next gnt no earlier than T_GAP+1 cycles after done.
//  Requester inputs are latched at grant; later changes (incl. req drop) do not affect the
//   running transaction, which always completes.
//  Simultaneous requests: lowest index wins; losers wait, no starvation guarantee.
//  rd_n and wr_n never low together; strobes only low while cs_n=0.
// STRUCTURE
//  Shared package: state encoding, requester index constants (REQ_INIT..REQ_EDATOS),
//   default timing constants.
//  Sub-module rtc_phase_timer: 8-bit down counter loaded with phase length, last-cycle flag.
//  Top holds FSM, priority encoder, latched transaction registers, pad output registers.
// TESTING (defaults)
//  Single write: req=5'b00010, addr=8'h21, wdata=8'h45 -> wr_n low 4 cyc with ad_n=0 ad_out=21,
//   then 4 cyc with ad_n=1 ad_out=45; done on 17th cycle of gnt=00010.
//  Single read: req[4], addr=8'h22, ad_in=8'h59 -> rd_n low 4 cyc, ad_oe=0 in data phase, rdata=59 at done.
//  Contention: req=5'b10011 same cycle -> gnt 00001, then 00010, then 10000; 3-cycle cs_n-high gap each.
//  Late request: req[1] rises while req[3] transaction busy -> req[3] completes, req[1] next.
//  Reset in D_PW: reset=1 -> next edge all strobes 1, ad_oe=0, gnt=0, no done pulse.
//  Req dropped in A_PW -> transaction completes and done pulses; ad_out unchanged.

Source files
------------

// File: rtl/rtc_bus_sequencer_pkg.sv
// Shared definitions for the RTC bus sequencer: FSM states, requester ids,
// default bus timing and the latched transaction record.
package rtc_bus_sequencer_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_A_SU,
        S_A_PW,
        S_A_H,
        S_D_SU,
        S_D_PW,
        S_D_H,
        S_DONE,
        S_GAP
    } state_t;

    // Requester index = priority (0 highest)
    localparam int REQ_INIT   = 0;
    localparam int REQ_GHORA  = 1;
    localparam int REQ_GFECHA = 2;
    localparam int REQ_GCRONO = 3;
    localparam int REQ_EDATOS = 4;

    localparam int DEF_NREQ  = 5;
    localparam int DEF_T_SU  = 2;
    localparam int DEF_T_PW  = 4;
    localparam int DEF_T_H   = 2;
    localparam int DEF_T_GAP = 3;

    // Requester inputs captured at grant time
    typedef struct packed {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
    } txn_t;

    function automatic logic is_addr_phase(input state_t s);
        return (s == S_A_SU) || (s == S_A_PW) || (s == S_A_H);
    endfunction

    function automatic logic is_data_phase(input state_t s);
        return (s == S_D_SU) || (s == S_D_PW) || (s == S_D_H);
    endfunction

endpackage

// File: rtl/rtc_bus_sequencer_timer.sv
// Phase length counter: loaded on entry to a timed phase, flags the last cycle.
module rtc_phase_timer (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] len,
    output logic       last
);

    logic [7:0] cnt;

    // Load the phase length, then count down to zero and stop
    always_ff @(posedge clock) begin
        if (reset)
            cnt <= 8'd0;
        else if (load)
            cnt <= len;
        else if (cnt != 8'd0)
            cnt <= cnt - 8'd1;
    end

    assign last = (cnt == 8'd1);

endmodule

// File: rtl/rtc_bus_sequencer.sv
// Arbitrates the RTC multiplexed address/data bus among the control sub-FSMs
// and runs one address+data bus cycle per grant. Pad outputs are registered
// from the next state so they change cleanly with the state register.
module rtc_bus_sequencer
    import rtc_bus_sequencer_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int T_SU  = DEF_T_SU,
    parameter int T_PW  = DEF_T_PW,
    parameter int T_H   = DEF_T_H,
    parameter int T_GAP = DEF_T_GAP
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ-1:0]     req_wr,
    input  logic [8*NREQ-1:0]   req_addr,
    input  logic [8*NREQ-1:0]   req_wdata,
    output logic [NREQ-1:0]     gnt,
    output logic                done,
    output logic [7:0]          rdata,
    output logic                busy,
    output logic                cs_n,
    output logic                rd_n,
    output logic                wr_n,
    output logic                ad_n,
    output logic [7:0]          ad_out,
    output logic                ad_oe,
    input  logic [7:0]          ad_in
);

    localparam logic [7:0] LEN_SU  = 8'(T_SU);
    localparam logic [7:0] LEN_PW  = 8'(T_PW);
    localparam logic [7:0] LEN_H   = 8'(T_H);
    localparam logic [7:0] LEN_GAP = 8'(T_GAP);

    state_t          state_q, state_d;
    txn_t            txn_q, txn_d, sel_txn;
    logic [NREQ-1:0] gnt_sel;
    logic            tmr_load;
    logic [7:0]      tmr_len;
    logic            tmr_last;

    rtc_phase_timer u_timer (
        .clock (clock),
        .reset (reset),
        .load  (tmr_load),
        .len   (tmr_len),
        .last  (tmr_last)
    );

    // Fixed-priority pick: scan from the top so the lowest set index wins
    always_comb begin
        gnt_sel = '0;
        sel_txn = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                gnt_sel       = '0;
                gnt_sel[i]    = 1'b1;
                sel_txn.wr    = req_wr[i];
                sel_txn.addr  = req_addr[8*i +: 8];
                sel_txn.wdata = req_wdata[8*i +: 8];
            end
        end
    end

    // Next state; each timed phase reloads the timer on entry
    always_comb begin
        state_d  = state_q;
        txn_d    = txn_q;
        tmr_load = 1'b0;
        tmr_len  = LEN_SU;
        unique case (state_q)
            S_IDLE: if (|req) begin
                txn_d    = sel_txn;
                state_d  = S_A_SU;
                tmr_load = 1'b1;
                tmr_len  = LEN_SU;
            end
            S_A_SU: if (tmr_last) begin
                state_d  = S_A_PW;
                tmr_load = 1'b1;
                tmr_len  = LEN_PW;
            end
            S_A_PW: if (tmr_last) begin
                state_d  = S_A_H;
                tmr_load = 1'b1;
                tmr_len  = LEN_H;
            end
            S_A_H: if (tmr_last) begin
                state_d  = S_D_SU;
                tmr_load = 1'b1;
                tmr_len  = LEN_SU;
            end
            S_D_SU: if (tmr_last) begin
                state_d  = S_D_PW;
                tmr_load = 1'b1;
                tmr_len  = LEN_PW;
            end
            S_D_PW: if (tmr_last) begin
                state_d  = S_D_H;
                tmr_load = 1'b1;
                tmr_len  = LEN_H;
            end
            S_D_H: if (tmr_last) begin
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d  = S_GAP;
                tmr_load = 1'b1;
                tmr_len  = LEN_GAP;
            end
            S_GAP: if (tmr_last) begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and latched transaction
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            txn_q   <= '0;
        end else begin
            state_q <= state_d;
            txn_q   <= txn_d;
        end
    end

    // Pad and handshake registers, decoded from the state being entered
    always_ff @(posedge clock) begin
        if (reset) begin
            gnt    <= '0;
            done   <= 1'b0;
            busy   <= 1'b0;
            cs_n   <= 1'b1;
            rd_n   <= 1'b1;
            wr_n   <= 1'b1;
            ad_n   <= 1'b1;
            ad_out <= 8'd0;
            ad_oe  <= 1'b0;
        end else begin
            done  <= (state_d == S_DONE);
            busy  <= (state_d != S_IDLE);
            cs_n  <= !(is_addr_phase(state_d) || is_data_phase(state_d));
            ad_n  <= !is_addr_phase(state_d);
            // The address is always latched into the RTC with a write strobe
            wr_n  <= !((state_d == S_A_PW) || ((state_d == S_D_PW) && txn_d.wr));
            rd_n  <= !((state_d == S_D_PW) && !txn_d.wr);
            ad_oe <= is_addr_phase(state_d) || (is_data_phase(state_d) && txn_d.wr);
            if (is_addr_phase(state_d))
                ad_out <= txn_d.addr;
            else if (is_data_phase(state_d) && txn_d.wr)
                ad_out <= txn_d.wdata;
            if ((state_d == S_IDLE) || (state_d == S_GAP))
                gnt <= '0;
            else if (state_q == S_IDLE)
                gnt <= gnt_sel;
        end
    end

    // Read data is sampled once, at the end of the read strobe
    always_ff @(posedge clock) begin
        if (reset)
            rdata <= 8'd0;
        else if ((state_q == S_D_PW) && tmr_last && !txn_q.wr)
            rdata <= ad_in;
    end

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Scoreboard bench for rtc_bus_sequencer: the driver queues expected
// transactions, the monitor checks each one when done pulses.
module tb_rtc_bus_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  req, req_wr, gnt;
    logic [39:0] req_addr, req_wdata;
    logic        done, busy, cs_n, rd_n, wr_n, ad_n, ad_oe;
    logic [7:0]  rdata, ad_out, ad_in;

    rtc_bus_sequencer dut (
        .clock(clock), .reset(reset), .req(req), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .done(done),
        .rdata(rdata), .busy(busy), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n),
        .ad_n(ad_n), .ad_out(ad_out), .ad_oe(ad_oe), .ad_in(ad_in)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [4:0] gnt;
        logic       wr;
        logic [7:0] addr;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   inv_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic set_slot(input int k, input logic wr, input logic [7:0] a, input logic [7:0] d);
        req_wr[k]        = wr;
        req_addr[8*k+:8]  = a;
        req_wdata[8*k+:8] = d;
    endtask

    task automatic expect_txn(input int k, input logic wr, input logic [7:0] a, input logic [7:0] d);
        exp_t e;
        e.gnt  = 5'(1 << k);
        e.wr   = wr;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic wait_done(input int k);
        bit ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clock); #1;
            if (done && gnt[k]) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            n_total++;
            $display("FAIL timeout: no done for requester %0d within 200 cycles", k);
        end
        @(negedge clock);
        req[k] = 1'b0;
    endtask

    // Monitor: tracks bus activity per transaction and checks on done
    initial begin
        int   lat = 0, a_cnt = 0, d_cnt = 0, hi_run = 0;
        logic [7:0] a_val = 0, d_val = 0;
        bit   a_bad = 0, oe_bad = 0, seen_txn = 0;
        logic [4:0] prev_gnt = 0;
        logic prev_cs_n = 1;
        exp_t e;
        forever begin
            @(posedge clock); #1;
            if (reset) begin
                lat = 0; a_cnt = 0; d_cnt = 0; hi_run = 0;
                a_bad = 0; oe_bad = 0; seen_txn = 0;
                prev_gnt = 0; prev_cs_n = 1;
            end else begin
                if (!rd_n && !wr_n) inv_bad++;
                if (cs_n && (!rd_n || !wr_n)) inv_bad++;
                if ($countones(gnt) > 1) inv_bad++;
                if (gnt != 0) lat = (prev_gnt == 0) ? 1 : lat + 1;
                if (!wr_n && !ad_n) begin
                    if (a_cnt == 0) a_val = ad_out;
                    else if (ad_out != a_val) a_bad = 1;
                    a_cnt++;
                end
                if (!wr_n && ad_n) begin d_cnt++; d_val = ad_out; end
                if (!rd_n) begin d_cnt++; if (ad_oe) oe_bad = 1; end
                if (!cs_n && prev_cs_n && seen_txn) begin
                    n_total++;
                    if (hi_run >= 4) n_pass++;
                    else $display("FAIL gap: cs_n high %0d cycles, need at least 4", hi_run);
                end
                hi_run = cs_n ? hi_run + 1 : 0;
                if (done) begin
                    if (exp_q.size() == 0) begin
                        n_total++;
                        $display("FAIL unexpected_done: gnt=%b with nothing expected", gnt);
                    end else begin
                        e = exp_q.pop_front();
                        chk("gnt", 32'(gnt), 32'(e.gnt));
                        chk("latency", 32'(lat), 32'd17);
                        chk("addr_strobe_cycles", 32'(a_cnt), 32'd4);
                        chk("addr_value", {a_bad, 23'd0, a_val}, {1'b0, 23'd0, e.addr});
                        chk("data_strobe_cycles", 32'(d_cnt), 32'd4);
                        if (e.wr) chk("wdata_on_bus", 32'(d_val), 32'(e.data));
                        else      chk("rdata", {oe_bad, 23'd0, rdata}, {1'b0, 23'd0, e.data});
                    end
                    lat = 0; a_cnt = 0; d_cnt = 0; a_bad = 0; oe_bad = 0;
                    seen_txn = 1;
                end
                prev_gnt  = gnt;
                prev_cs_n = cs_n;
            end
        end
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Driver
    initial begin
        bit seen_rd;
        reset = 1'b1; req = '0; req_wr = '0; req_addr = '0; req_wdata = '0; ad_in = 8'h00;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_gnt",    32'(gnt), 32'd0);
        chk("rst_done",   32'(done), 32'd0);
        chk("rst_rdata",  32'(rdata), 32'd0);
        chk("rst_busy",   32'(busy), 32'd0);
        chk("rst_strobes", {28'd0, cs_n, rd_n, wr_n, ad_n}, 32'hF);
        chk("rst_ad_out", 32'(ad_out), 32'd0);
        chk("rst_ad_oe",  32'(ad_oe), 32'd0);
        @(negedge clock); reset = 1'b0;
        repeat (2) @(negedge clock);

        // Single write from ghora
        set_slot(1, 1'b1, 8'h21, 8'h45); expect_txn(1, 1'b1, 8'h21, 8'h45);
        req[1] = 1'b1;
        wait_done(1);

        // Single read from edatos
        ad_in = 8'h59;
        set_slot(4, 1'b0, 8'h22, 8'h00); expect_txn(4, 1'b0, 8'h22, 8'h59);
        req[4] = 1'b1;
        wait_done(4);

        // Contention: 0 then 1 then 4
        repeat (6) @(negedge clock);
        ad_in = 8'hA6;
        set_slot(0, 1'b1, 8'h0F, 8'h80); expect_txn(0, 1'b1, 8'h0F, 8'h80);
        set_slot(1, 1'b1, 8'h30, 8'h12); expect_txn(1, 1'b1, 8'h30, 8'h12);
        set_slot(4, 1'b0, 8'h33, 8'h00); expect_txn(4, 1'b0, 8'h33, 8'hA6);
        req = 5'b10011;
        wait_done(0);
        wait_done(1);
        wait_done(4);

        // Late higher-priority request while gcrono is running
        repeat (6) @(negedge clock);
        set_slot(3, 1'b1, 8'h10, 8'h7E); expect_txn(3, 1'b1, 8'h10, 8'h7E);
        req[3] = 1'b1;
        repeat (5) @(negedge clock);
        ad_in = 8'hC3;
        set_slot(1, 1'b0, 8'h11, 8'h00); expect_txn(1, 1'b0, 8'h11, 8'hC3);
        req[1] = 1'b1;
        wait_done(3);
        wait_done(1);

        // Request and inputs dropped during the address strobe
        repeat (6) @(negedge clock);
        set_slot(2, 1'b1, 8'h05, 8'h99); expect_txn(2, 1'b1, 8'h05, 8'h99);
        req[2] = 1'b1;
        repeat (5) @(negedge clock);
        req[2] = 1'b0;
        set_slot(2, 1'b0, 8'hEE, 8'h11);
        wait_done(2);

        // Reset during the read strobe aborts without done
        repeat (6) @(negedge clock);
        ad_in = 8'h77;
        set_slot(4, 1'b0, 8'h2A, 8'h00);
        req[4] = 1'b1;
        seen_rd = 0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clock); #1;
            if (!rd_n) begin seen_rd = 1; break; end
        end
        chk("abort_reached_read_strobe", 32'(seen_rd), 32'd1);
        reset = 1'b1;
        @(posedge clock); #1;
        chk("abort_strobes", {28'd0, cs_n, rd_n, wr_n, ad_n}, 32'hF);
        chk("abort_ad_oe",   32'(ad_oe), 32'd0);
        chk("abort_gnt",     32'(gnt), 32'd0);
        chk("abort_done",    32'(done), 32'd0);
        chk("abort_busy",    32'(busy), 32'd0);
        chk("abort_rdata",   32'(rdata), 32'd0);
        @(negedge clock); reset = 1'b0; req = '0;
        repeat (30) @(negedge clock);

        // Recovery after abort
        set_slot(0, 1'b1, 8'h3C, 8'h5A); expect_txn(0, 1'b1, 8'h3C, 8'h5A);
        req[0] = 1'b1;
        wait_done(0);

        repeat (10) @(negedge clock);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        chk("bus_invariants",   32'(inv_bad), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
